// File: rtl/vgc_irq_ctrl_pkg.sv
// vgc_irq_pkg: shared constants for the VGC interrupt controller.
// Holds the $C0xx register address map, the bit positions used in the
// software-visible registers, the internal event-source indices and the
// register-select decode. Optional build macro used by the design that
// imports this package: QTR_VBL_SYNC_EN.
package vgc_irq_pkg;

    // Low byte of each $C0xx register handled by this block
    localparam logic [7:0] ADDR_VGCINT   = 8'h23;
    localparam logic [7:0] ADDR_SCANINT  = 8'h32;
    localparam logic [7:0] ADDR_INTEN    = 8'h41;
    localparam logic [7:0] ADDR_DIAGTYPE = 8'h46;
    localparam logic [7:0] ADDR_CLRVBL   = 8'h47;

    // $C023 bit positions
    localparam int BIT_VGC_PEND = 7;
    localparam int BIT_ST_1S    = 6;
    localparam int BIT_ST_SCAN  = 5;
    localparam int BIT_EN_1S    = 2;
    localparam int BIT_EN_SCAN  = 1;

    // $C041 bit positions (mouse enables occupy [2:0])
    localparam int BIT_EN_QTR   = 4;
    localparam int BIT_EN_VBL   = 3;
    localparam int MOUSE_EN_W   = 3;

    // $C046 bit positions
    localparam int BIT_ST_QTR   = 4;
    localparam int BIT_ST_VBL   = 3;

    // Index of each interrupt source in the internal enable/status vectors
    localparam int SRC_1S   = 0;
    localparam int SRC_SCAN = 1;
    localparam int SRC_QTR  = 2;
    localparam int SRC_VBL  = 3;
    localparam int NUM_SRC  = 4;

    // Which register an address selects
    typedef enum logic [2:0] {
        REG_NONE,
        REG_VGCINT,
        REG_SCANINT,
        REG_INTEN,
        REG_DIAGTYPE,
        REG_CLRVBL
    } reg_sel_e;

    // Map the low address byte onto a register select
    function automatic reg_sel_e decodeReg(input logic [7:0] addrLow);
        reg_sel_e sel;
        case (addrLow)
            ADDR_VGCINT:   sel = REG_VGCINT;
            ADDR_SCANINT:  sel = REG_SCANINT;
            ADDR_INTEN:    sel = REG_INTEN;
            ADDR_DIAGTYPE: sel = REG_DIAGTYPE;
            ADDR_CLRVBL:   sel = REG_CLRVBL;
            default:       sel = REG_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/vgc_irq_ctrl_latch.sv
// irq_latch: one sticky interrupt status bit.
// The bit sets when its event pulses while enabled and clears on a
// software clear; a set and a clear in the same cycle leave the bit set.
// req is the status qualified by the current enable.
module irq_latch (
    input  logic CLK_14M,
    input  logic reset,
    input  logic set_ev,
    input  logic en,
    input  logic clr,
    output logic st,
    output logic req
);

    logic st_q;

    // Sticky status bit: an enabled event takes priority over a clear
    always_ff @(posedge CLK_14M or posedge reset) begin
        if (reset) begin
            st_q <= 1'b0;
        end else if (set_ev && en) begin
            st_q <= 1'b1;
        end else if (clr) begin
            st_q <= 1'b0;
        end
    end

    assign st  = st_q;
    assign req = st_q & en;

endmodule

// File: rtl/vgc_irq_ctrl.sv
// vgc_irq_ctrl: IIgs VGC interrupt aggregation.
// Latches the PRTC one-second and quarter-second pulses and the video
// scanline and VBL pulses into status bits, exposes the $C023, $C032,
// $C041, $C046 and $C047 registers, and drives a registered level irq.
// Build macro QTR_VBL_SYNC_EN: when defined, a quarter-second pulse is held
// pending and only lands in the status bit at the next vbl_start.
module vgc_irq_ctrl
    import vgc_irq_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              CLK_14M,
    input  logic              reset,
    input  logic              cen,
    input  logic [ADDR_W-1:0] addr,
    input  logic              rw,
    input  logic              strobe,
    input  logic [7:0]        din,
    output logic [7:0]        dout,
    input  logic              onesecond_irq,
    input  logic              qtrsecond_irq,
    input  logic              scanline_irq,
    input  logic              vbl_start,
    output logic              irq
);

    logic [7:0]            addrLow;
    reg_sel_e              regSel;
    logic                  wrEn;

    logic [NUM_SRC-1:0]    en_q;
    logic [NUM_SRC-1:0]    en_d;
    logic [MOUSE_EN_W-1:0] mouseEn_q;
    logic [MOUSE_EN_W-1:0] mouseEn_d;
    logic [7:0]            dout_q;
    logic [7:0]            dout_d;
    logic                  irq_q;
    logic                  irq_d;

    logic [NUM_SRC-1:0]    setEv;
    logic [NUM_SRC-1:0]    clrEv;
    logic [NUM_SRC-1:0]    stVec;
    logic [NUM_SRC-1:0]    reqVec;
    logic [7:0]            rdData;

    // din[7] carries no meaning in any register written here
    logic                  unusedDin;
    assign unusedDin = din[7];

    assign addrLow = 8'(addr);
    assign regSel  = decodeReg(addrLow);
    assign wrEn    = strobe && cen && !rw;

    // Enable and mouse-enable next state from $C023 / $C041 writes
    always_comb begin
        en_d      = en_q;
        mouseEn_d = mouseEn_q;
        if (wrEn && (regSel == REG_VGCINT)) begin
            en_d[SRC_1S]   = din[BIT_EN_1S];
            en_d[SRC_SCAN] = din[BIT_EN_SCAN];
        end
        if (wrEn && (regSel == REG_INTEN)) begin
            en_d[SRC_QTR] = din[BIT_EN_QTR];
            en_d[SRC_VBL] = din[BIT_EN_VBL];
            mouseEn_d     = din[MOUSE_EN_W-1:0];
        end
    end

    // Software clears: $C032 clears on written zeros, $C047 clears on any write
    always_comb begin
        clrEv           = '0;
        clrEv[SRC_1S]   = wrEn && (regSel == REG_SCANINT) && !din[BIT_ST_1S];
        clrEv[SRC_SCAN] = wrEn && (regSel == REG_SCANINT) && !din[BIT_ST_SCAN];
        clrEv[SRC_QTR]  = wrEn && (regSel == REG_CLRVBL);
        clrEv[SRC_VBL]  = wrEn && (regSel == REG_CLRVBL);
    end

`ifdef QTR_VBL_SYNC_EN
    logic qtrPend_q;
    logic qtrPend_d;

    // Quarter-second pending flag: armed by an enabled pulse, consumed by VBL
    always_comb begin
        qtrPend_d = qtrPend_q;
        if (clrEv[SRC_QTR] || !en_q[SRC_QTR]) begin
            qtrPend_d = 1'b0;
        end else if (qtrsecond_irq) begin
            qtrPend_d = 1'b1;
        end else if (vbl_start) begin
            qtrPend_d = 1'b0;
        end
    end

    // Pending-flag register
    always_ff @(posedge CLK_14M or posedge reset) begin
        if (reset) begin
            qtrPend_q <= 1'b0;
        end else begin
            qtrPend_q <= qtrPend_d;
        end
    end

    // Event sources; the quarter-second status waits for VBL alignment
    always_comb begin
        setEv           = '0;
        setEv[SRC_1S]   = onesecond_irq;
        setEv[SRC_SCAN] = scanline_irq;
        setEv[SRC_QTR]  = qtrPend_q && vbl_start;
        setEv[SRC_VBL]  = vbl_start;
    end
`else
    // Event sources; the quarter-second pulse sets its status directly
    always_comb begin
        setEv           = '0;
        setEv[SRC_1S]   = onesecond_irq;
        setEv[SRC_SCAN] = scanline_irq;
        setEv[SRC_QTR]  = qtrsecond_irq;
        setEv[SRC_VBL]  = vbl_start;
    end
`endif

    // One sticky status latch per interrupt source
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_latch
        irq_latch u_latch (
            .CLK_14M (CLK_14M),
            .reset   (reset),
            .set_ev  (setEv[gi]),
            .en      (en_q[gi]),
            .clr     (clrEv[gi]),
            .st      (stVec[gi]),
            .req     (reqVec[gi])
        );
    end

    // Read-data mux; $C032 and $C047 are write-only and read back as zero
    always_comb begin
        rdData = 8'h00;
        case (regSel)
            REG_VGCINT: begin
                rdData[BIT_VGC_PEND] = reqVec[SRC_1S] | reqVec[SRC_SCAN];
                rdData[BIT_ST_1S]    = stVec[SRC_1S];
                rdData[BIT_ST_SCAN]  = stVec[SRC_SCAN];
                rdData[BIT_EN_1S]    = en_q[SRC_1S];
                rdData[BIT_EN_SCAN]  = en_q[SRC_SCAN];
            end
            REG_INTEN: begin
                rdData[BIT_EN_QTR]           = en_q[SRC_QTR];
                rdData[BIT_EN_VBL]           = en_q[SRC_VBL];
                rdData[MOUSE_EN_W-1:0]       = mouseEn_q;
            end
            REG_DIAGTYPE: begin
                rdData[BIT_ST_QTR] = stVec[SRC_QTR];
                rdData[BIT_ST_VBL] = stVec[SRC_VBL];
            end
            default: rdData = 8'h00;
        endcase
    end

    // dout follows any read of a known register, independent of strobe; holds otherwise
    always_comb begin
        dout_d = dout_q;
        if (rw && (regSel != REG_NONE)) begin
            dout_d = rdData;
        end
        irq_d = |reqVec;
    end

    // Enables, mouse enables, read data and the irq level
    always_ff @(posedge CLK_14M or posedge reset) begin
        if (reset) begin
            en_q      <= '0;
            mouseEn_q <= '0;
            dout_q    <= 8'h00;
            irq_q     <= 1'b0;
        end else begin
            en_q      <= en_d;
            mouseEn_q <= mouseEn_d;
            dout_q    <= dout_d;
            irq_q     <= irq_d;
        end
    end

    assign dout = dout_q;
    assign irq  = irq_q;

endmodule

// File: doc/vgc_irq_ctrl.md
Name: vgc_irq_ctrl

Overview:
- Interrupt aggregation stage directly downstream of the PRTC clock block. Consumes its onesecond_irq and qtrsecond_irq pulses, plus video scanline and VBL pulses.
- Latches each event into software-visible status registers and exposes the IIgs enable/status/clear registers $C023, $C032, $C041, $C046 and $C047.
- Drives one level interrupt request to the 65C816 core.

Parameters:
- ADDR_W, 8, width of the $C0xx low address byte.

Ports:
- CLK_14M  input  1  system clock; one clock, all logic on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- cen  input  1  CPU clock enable; qualifies strobe.
- addr  input  8  low byte of the $C0xx I/O address.
- rw  input  1  1 = read, 0 = write.
- strobe  input  1  register access; high for exactly one cen cycle.
- din  input  8  write data.
- dout  output  8  registered read data.
- onesecond_irq  input  1  one-CLK_14M pulse from the PRTC.
- qtrsecond_irq  input  1  one-CLK_14M pulse from the PRTC.
- scanline_irq  input  1  one-CLK_14M pulse from video at a flagged scanline.
- vbl_start  input  1  one-CLK_14M pulse at the start of vertical blank.
- irq  output  1  level interrupt request to the CPU, active-high.

Behaviour:
- Reset (async): all enables, all status bits, dout and irq go to 0.
- Registers:
  - en_1s, en_scan, en_qtr, en_vbl (enables).
  - st_1s, st_scan, st_qtr, st_vbl (status).
  - mouse_en[2:0] (stored only, no function).
- Event latch: on an event pulse, its status bit sets only if its enable is 1 in that same cycle. Events are sampled every CLK_14M, independent of cen.
- A write to a register takes effect only when strobe && cen && !rw.
- $C023 write: en_1s = din[2], en_scan = din[1]. All other bits are ignored.
- $C023 read: bit7 = (st_1s & en_1s) | (st_scan & en_scan); bit6 = st_1s; bit5 = st_scan; bit2 = en_1s; bit1 = en_scan; other bits 0.
- $C032 write:
  - din[6] = 0 clears st_1s; din[5] = 0 clears st_scan.
  - Writing 1 to a bit has no effect.
- $C041 write: en_qtr = din[4], en_vbl = din[3], mouse_en = din[2:0].
- $C041 read: {3'b0, en_qtr, en_vbl, mouse_en}.
- $C046 read: bit7 = 0, bit4 = st_qtr, bit3 = st_vbl, other bits 0. Reads never clear status.
- $C047 write: any data clears st_qtr and st_vbl.
- Read timing:
  - dout updates on the CLK_14M edge after any cycle where rw = 1 and addr matches a register, regardless of strobe (1-clock latency).
  - dout holds its value for unmatched addresses.
  - $C032 and $C047 read as 8'h00.
- irq: registered OR of all (status & enable) pairs; 1 clock after the status or enable change.
  - Clearing an enable drops irq but leaves the status bit set.
  - Re-enabling while the status bit is still set reasserts irq.
- Simultaneous event pulse and clear of the same bit in one cycle: set wins; the status bit ends at 1.
- Reset asserted mid-access: the access is abandoned; dout = 0 on release.

Optional Feature:
- Macro: QTR_VBL_SYNC_EN.
- Defined: a qtrsecond_irq pulse with en_qtr = 1 sets an internal qtr_pend flag.
  - st_qtr sets on the next vbl_start pulse, matching real hardware alignment to VBL.
  - If qtr_pend is set and vbl_start arrives in the same cycle as a new qtrsecond_irq, st_qtr sets and qtr_pend stays set.
  - A $C047 write or en_qtr = 0 clears qtr_pend.
- Undefined: st_qtr sets directly on the qtrsecond_irq pulse; no qtr_pend flag exists.

Decomposition:
- Package vgc_irq_pkg:
  - Address constants ADDR_VGCINT = 8'h23, ADDR_SCANINT = 8'h32, ADDR_INTEN = 8'h41, ADDR_DIAGTYPE = 8'h46, ADDR_CLRVBL = 8'h47.
  - Bit-index constants for each enable and status bit.
- Sub-module irq_latch:
  - Inputs: set_ev, en, clr. Outputs: st, req = st & en.
  - Implements set-wins priority.
  - Instantiated four times.

Test Plan:
- Reset, then write $C023 = 8'h04 and pulse onesecond_irq → $C023 reads 8'hC4; irq = 1 one clock after the pulse.
- Write $C032 = 8'hBF (din[6] = 0) → $C023 reads 8'h04; irq = 0. A write of 8'hFF leaves the status unchanged.
- With en_scan = 0, pulse scanline_irq → st_scan stays 0. Then enable scan and pulse in the same cycle as a $C032 = 8'hDF write → st_scan = 1 (set wins).
- Write $C041 = 8'h18; pulse vbl_start and qtrsecond_irq → $C046 reads 8'h18. Write $C047 = 8'h00 → reads 8'h00; irq = 0.
- QTR_VBL_SYNC_EN defined: qtrsecond_irq at t0 → $C046 bit4 = 0 until vbl_start at t0+1000, then 1 on the next clock.
- Assert reset while st_1s = 1 and irq = 1 → irq and dout go to 0 immediately (asynchronous); $C023 reads 8'h00 after release.
